// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter with one register stage per shift level (largest first).
// Valid/ready handshakes on both sides; bubbles collapse while the output is stalled.
module pipelined_barrel_shifter #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       m,
                                                   input logic             fill,
                                                   input int               amt);
    logic [WIDTH-1:0] fill_mask;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    case (m)
      3'b000:  level_shift = d << amt;
      3'b001:  level_shift = d >> amt;
      3'b010:  level_shift = (d >> amt) | (fill ? fill_mask : '0);
      3'b011:  level_shift = (d << amt) | (d >> (WIDTH - amt));
      3'b100:  level_shift = (d >> amt) | (d << (WIDTH - amt));
      default: level_shift = d;
    endcase
  endfunction

  logic [SHW-1:0]   valid_q;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [2:0]       mode_q  [SHW];
  logic             fill_q  [SHW];

  logic [SHW:0]     load;
  logic [SHW-1:0]   src_valid;
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [2:0]       src_mode  [SHW];
  logic             src_fill  [SHW];
  logic [WIDTH-1:0] next_data [SHW];

  // A stage may load when it is empty or its occupant leaves this cycle;
  // the chain runs combinationally from out_ready back to in_ready.
  always_comb begin
    load      = '0;
    load[SHW] = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || load[k+1];
    end
  end

  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = shamt;
    src_mode[0]  = mode;
    src_fill[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_fill[k]  = fill_q[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      next_data[k] = src_shamt[k][SHW-1-k]
                   ? level_shift(src_data[k], src_mode[k], src_fill[k], 1 << (SHW - 1 - k))
                   : src_data[k];
    end
  end

  // Payload only updates when a valid operand arrives, so a drained stage keeps its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        fill_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (load[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k]  <= next_data[k];
            shamt_q[k] <= src_shamt[k];
            mode_q[k]  <= src_mode[k];
            fill_q[k]  <= src_fill[k];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = valid_q[SHW-1] && (data_q[SHW-1] == '0);

endmodule
